qsub_serial: RTL and testbench



---
 rtl/qsub_serial.sv | 169 ++++++++++++++++
 tb/tb_qsub_serial.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/qsub_serial.sv
// Bit-serial sign-magnitude subtractor c = a - b, one magnitude bit per clock, LSB first.
// Operands with unlike signs take the magnitude-add path; a final borrow triggers a serial negate.
module qsub_serial #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         ovf
);

   localparam int M  = N - 1;
   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   if (Q < 0 || Q >= M) begin : g_q_range
      $error("qsub_serial: Q must lie in [0, N-2]");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cb_q, cb_d;
   logic            op_add_q, op_add_d;
   logic            sign_a_q, sign_a_d;
   logic [N-1:0]    c_q, c_d;
   logic            ovf_q, ovf_d;
   logic [M-1:0]    a_sh_q, a_sh_d;
   logic [M-1:0]    b_sh_q, b_sh_d;
   logic [M-1:0]    mag_q, mag_d;

   logic            abit, bbit;
   logic            sum_bit, cb_next;
   logic            neg_bit, k_next;
   logic [M-1:0]    mag_calc, mag_neg;

   // Zero magnitude always carries a positive sign.
   function automatic logic [N-1:0] pack_result(input logic sign, input logic [M-1:0] mag);
      return {sign & (|mag), mag};
   endfunction

   function automatic logic carry_out(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

   function automatic logic borrow_out(input logic x, input logic y, input logic bi);
      return (~x & y) | (~(x ^ y) & bi);
   endfunction

   always_comb begin
      abit     = a_sh_q[0];
      bbit     = b_sh_q[0];
      sum_bit  = abit ^ bbit ^ cb_q;
      cb_next  = op_add_q ? carry_out(abit, bbit, cb_q) : borrow_out(abit, bbit, cb_q);
      neg_bit  = ~mag_q[0] ^ cb_q;
      k_next   = ~mag_q[0] & cb_q;
      mag_calc = {sum_bit, mag_q[M-1:1]};
      mag_neg  = {neg_bit, mag_q[M-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cb_d     = cb_q;
      op_add_d = op_add_q;
      sign_a_d = sign_a_q;
      c_d      = c_q;
      ovf_d    = ovf_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      mag_d    = mag_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d   = a[M-1:0];
               b_sh_d   = b[M-1:0];
               op_add_d = a[N-1] ^ b[N-1];
               sign_a_d = a[N-1];
               cnt_d    = '0;
               cb_d     = 1'b0;
               state_d  = CALC;
            end
         end
         CALC: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            mag_d  = mag_calc;
            cb_d   = cb_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (!op_add_q && cb_next) begin
                  // Borrow out means b > a in magnitude: negate, carry-in 1 on bit 0.
                  cb_d    = 1'b1;
                  state_d = NEG;
               end else begin
                  c_d     = pack_result(sign_a_q, mag_calc);
                  ovf_d   = op_add_q & cb_next;
                  state_d = DONE;
               end
            end
         end
         NEG: begin
            mag_d = mag_neg;
            cb_d  = k_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               c_d     = pack_result(~sign_a_q, mag_neg);
               ovf_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cb_q     <= 1'b0;
         op_add_q <= 1'b0;
         sign_a_q <= 1'b0;
         c_q      <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cb_q     <= cb_d;
         op_add_q <= op_add_d;
         sign_a_q <= sign_a_d;
         c_q      <= c_d;
         ovf_q    <= ovf_d;
      end
   end

   // Operand and magnitude shift registers carry no reset; they are reloaded at every accept.
   always_ff @(posedge clk) begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      mag_q  <= mag_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign c         = c_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_qsub_serial.sv
// Directed bench for qsub_serial: vector table plus back-pressure and mid-operation reset sequences.
module tb_qsub_serial;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] c;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   qsub_serial #(.Q(15), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .ovf       (ovf)
   );

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 200);
   endtask

   task automatic release_out(input string name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({name, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
      check({name, "_iready_back"}, {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [31:0] held_c;
      int seen;

      vecs[0] = '{"sub_3m1",      32'h00018000, 32'h00008000, 32'h00010000, 1'b0, 31};
      vecs[1] = '{"sub_1m3_neg",  32'h00008000, 32'h00018000, 32'h80010000, 1'b0, 62};
      vecs[2] = '{"add_1mm2",     32'h00008000, 32'h80010000, 32'h00018000, 1'b0, 31};
      vecs[3] = '{"negzero",      32'h8000C000, 32'h8000C000, 32'h00000000, 1'b0, 31};
      vecs[4] = '{"ovf_wrap",     32'h7FFFFFFF, 32'h80000001, 32'h00000000, 1'b1, 31};
      vecs[5] = '{"neg_m2mm1",    32'h80010000, 32'h80008000, 32'h80008000, 1'b0, 31};
      vecs[6] = '{"zero_m1lsb",   32'h00000000, 32'h00000001, 32'h80000001, 1'b0, 62};
      vecs[7] = '{"neg_sub_flip", 32'h80008000, 32'h80018000, 32'h00010000, 1'b0, 62};

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_c", c, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         check({vecs[i].name, "_busy"}, {31'd0, in_ready}, 32'd0);
         wait_done(lat);
         check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
         check({vecs[i].name, "_c"}, c, vecs[i].c);
         check({vecs[i].name, "_ovf"}, {31'd0, ovf}, {31'd0, vecs[i].ovf});
         release_out(vecs[i].name);
      end

      // Back-pressure: result and flags hold, new operands ignored.
      start_op(32'h00018000, 32'h00008000);
      wait_done(lat);
      check("hold_lat", lat, 31);
      held_c = c;
      check("hold_c0", held_c, 32'h00010000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a = 32'h12345678;
         b = 32'h00000001;
         @(posedge clk);
         #1;
         check("hold_c", c, 32'h00010000);
         check("hold_ovalid", {31'd0, out_valid}, 32'd1);
         check("hold_iready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      release_out("hold");

      // Reset while bit 10 is being processed.
      start_op(32'h00008000, 32'h00018000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_ovalid", {31'd0, out_valid}, 32'd0);
      check("midrst_c", c, 32'd0);
      check("midrst_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_iready", {31'd0, in_ready}, 32'd1);
      seen = 0;
      for (int k = 0; k < 70; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("midrst_no_output", seen, 0);

      start_op(32'h00008000, 32'h80010000);
      wait_done(lat);
      check("recover_lat", lat, 31);
      check("recover_c", c, 32'h00018000);
      release_out("recover");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
